// File: rtl/pool_axis_window.sv
// Pools POOL_K consecutive AXI-Stream beats per lane (bypass / signed max / average) into one output beat.
// Latency: result registered on the edge that accepts the closing beat; stalls upstream only while the output register is full.
module pool_axis_window #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_CORES = 4,
  parameter int POOL_K     = 2
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [1:0]                       pool_mode,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [DATA_WIDTH*CONV_CORES-1:0] s_axis_tdata,
  input  logic                             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH*CONV_CORES-1:0] m_axis_tdata,
  output logic                             m_axis_tlast
);

  localparam int LOGK = $clog2(POOL_K);
  localparam int CW   = (LOGK > 0) ? LOGK : 1;
  localparam int AW   = DATA_WIDTH + LOGK;
  localparam int BW   = DATA_WIDTH * CONV_CORES;

  localparam logic [1:0] MODE_MAX = 2'b01;
  localparam logic [1:0] MODE_AVG = 2'b10;

  logic [CW-1:0] cnt;
  logic [1:0]    mode_q;
  logic          last_acc;
  logic [1:0]    mode_eff;
  logic          first;
  logic          accept;
  logic          close;
  logic          bypass;
  logic [BW-1:0] pool_dat;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first         = (cnt == '0);
  // The mode seen on the opening beat governs the rest of the window.
  assign mode_eff      = first ? pool_mode : mode_q;
  assign bypass        = (POOL_K == 1) || !((mode_eff == MODE_MAX) || (mode_eff == MODE_AVG));
  assign close         = (cnt == CW'(POOL_K - 1)) || s_axis_tlast;

  for (genvar g = 0; g < CONV_CORES; g++) begin : g_lane
    logic signed [AW-1:0] lane_ext;
    logic signed [AW-1:0] acc_nx;
    logic signed [AW-1:0] acc_q;

    assign lane_ext = AW'($signed(s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]));

    always_comb begin
      acc_nx = lane_ext;
      if (!first) begin
        if (mode_eff == MODE_MAX) begin
          acc_nx = (lane_ext > acc_q) ? lane_ext : acc_q;
        end else begin
          acc_nx = acc_q + lane_ext;
        end
      end
    end

    // Average always divides by POOL_K, so a short window reads as zero-padded.
    assign pool_dat[g*DATA_WIDTH +: DATA_WIDTH] = (mode_eff == MODE_MAX)
                                                ? acc_nx[DATA_WIDTH-1:0]
                                                : DATA_WIDTH'(acc_nx >>> LOGK);

    always_ff @(posedge aclk) begin
      if (areset) begin
        acc_q <= '0;
      end else if (accept && !bypass) begin
        acc_q <= acc_nx;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt           <= '0;
      mode_q        <= 2'b00;
      last_acc      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        if (first) begin
          mode_q <= pool_mode;
        end
        if (bypass) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= s_axis_tdata;
          m_axis_tlast  <= s_axis_tlast;
          cnt           <= '0;
          last_acc      <= 1'b0;
        end else if (close) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= pool_dat;
          m_axis_tlast  <= last_acc || s_axis_tlast;
          cnt           <= '0;
          last_acc      <= 1'b0;
        end else begin
          cnt      <= cnt + 1'b1;
          last_acc <= last_acc || s_axis_tlast;
        end
      end
    end
  end

endmodule

// File: doc/pool_axis_window.md
POOL_AXIS_WINDOW -- requirements
Module: pool_axis_window

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed lane width in bits.
REQ-002 Parameter CONV_CORES, default 4: lanes per beat.
REQ-003 Parameter POOL_K, default 2: beats per pooling window; legal values are 1, 2, 4, 8 and 16.
REQ-004 aclk  input  1: the single clock; all logic is rising-edge.
REQ-005 areset  input  1: reset, synchronous and active-high.
REQ-006 pool_mode  input  2: pooling mode; 00 = bypass, 01 = max, 10 = average, 11 = reserved (treated as bypass).
REQ-007 s_axis_tvalid  input  1: upstream beat valid.
REQ-008 s_axis_tready  output  1: block accepts the beat.
REQ-009 s_axis_tdata  input  DATA_WIDTH*CONV_CORES: lanes; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 s_axis_tlast  input  1: end of row.
REQ-011 m_axis_tvalid  output  1: output beat valid.
REQ-012 m_axis_tready  input  1: downstream ready.
REQ-013 m_axis_tdata  output  DATA_WIDTH*CONV_CORES: pooled lanes, same lane layout as s_axis_tdata.
REQ-014 m_axis_tlast  output  1: end of row on the output.

Function
REQ-015 A beat is accepted when s_axis_tvalid and s_axis_tready are both high; an output beat is taken when m_axis_tvalid and m_axis_tready are both high.
REQ-016 s_axis_tready = !m_axis_tvalid || m_axis_tready, so a full output register with a stalled sink applies backpressure.
REQ-017 Window counter cnt runs 0..POOL_K-1 (width clog2(POOL_K), minimum 1); it increments per accepted beat and returns to 0 on window close.
REQ-018 pool_mode is latched when a beat is accepted at cnt==0; the latched value governs the whole window.
REQ-019 Bypass: each accepted beat is copied to the output register on the next edge, including its tlast; cnt stays 0.
REQ-020 Max: per lane, acc = first beat at cnt==0, else signed max(acc, beat).
REQ-021 Average: per lane, accumulator of width DATA_WIDTH+log2(POOL_K); sum = first beat at cnt==0, else sum + beat (signed); output = sum arithmetic-shifted right by log2(POOL_K), truncated to DATA_WIDTH.
REQ-022 A window closes on the accepted beat where cnt==POOL_K-1 or s_axis_tlast==1, whichever occurs first.
REQ-023 On close, the final combined result (including the closing beat) loads the output register on that same edge; m_axis_tvalid rises one cycle after the closing beat is accepted.
REQ-024 m_axis_tlast = OR of tlast over the window's beats.
REQ-025 A partial window closed by tlast is still divided by POOL_K in average mode (zero-padding semantics); max uses only the received beats.
REQ-026 POOL_K==1 behaves as bypass in every mode.
REQ-027 The output register holds data and tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-028 Simultaneous output take and window close in the same cycle: the register reloads with no bubble, sustaining 1 output beat per POOL_K input beats at full throughput.
REQ-029 pool_mode changes mid-window have no effect until the next cnt==0.

Reset
REQ-030 While areset is high: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, cnt=0, accumulators=0, latched mode=00; s_axis_tready=1 on the first cycle after release.
REQ-031 Reset asserted mid-window discards the partial window and any pending output beat; no beat is emitted for it after release.

Verification
REQ-032 Bench: POOL_K=2, max mode, lane0 beats 5 then -3, tlast 0/1, sink always ready -> one output beat, lane0=5, tlast=1, m_axis_tvalid exactly 1 cycle after the 2nd beat.
REQ-033 Bench: POOL_K=4, average mode, lane0 beats 4,8,-2,6 -> output 4 (sum 16 >> 2).
REQ-034 Bench: POOL_K=4, average mode, lane0 beats 8,8 with tlast on the 2nd -> output 4, tlast=1, cnt=0 afterwards.
REQ-035 Bench: POOL_K=2, max mode, sink ready low for 5 cycles with source continuously valid -> s_axis_tready falls after the output register fills, m_axis_tdata stays stable, no loss or duplication, order preserved.
REQ-036 Bench: bypass mode, 8 beats at full rate -> 8 identical output beats, 1-cycle latency, tlast positions preserved.
REQ-037 Bench: areset pulsed after 1 of 2 max-mode beats -> no output for that window; the next full window (7, 9) outputs 9.
